// File: rtl/i2c_master_txgen.sv
// i2c_master_txgen: single-shot I2C master that issues one complete TCPC
// register write or register read per accepted start pulse. SDA is open
// drain (sda_oe=1 pulls low); SCL is driven and never read back.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | bus released, waiting for start
// START   | SCL high, SDA pulled low for one half period
// ID      | slave ID byte ({ID,0}, or {ID,1} after RSTART), bit 8 = ACK
// REG     | register address bytes, MS byte first, bit 8 = ACK
// WDATA   | write data bytes, MS byte first, bit 8 = ACK
// RSTART  | repeated start cell
// RDATA   | read data bytes, bit 8 = master ACK/NACK
// STOP    | stop cell, then done pulse
module i2c_master_txgen #(
  parameter int         HALF       = 125,
  parameter logic [6:0] SLAVE_ID   = 7'h7F,
  parameter int         REG_BYTES  = 2,
  parameter int         DATA_BYTES = 2
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic                    start,
  input  logic                    rw,
  input  logic [8*REG_BYTES-1:0]  reg_addr,
  input  logic [8*DATA_BYTES-1:0] wdata,
  input  logic                    iSDA,
  output logic                    sda_oe,
  output logic                    SCL,
  output logic                    busy,
  output logic                    done,
  output logic                    nack,
  output logic [8*DATA_BYTES-1:0] rdata
);

  localparam int PW   = $clog2(HALF);
  localparam int MAXB = (REG_BYTES > DATA_BYTES) ? REG_BYTES : DATA_BYTES;
  localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(HALF - 1);
  localparam logic [PW-1:0] PH_MID   = PW'(HALF / 2);
  localparam logic [PW-1:0] PH_PRE   = PW'(HALF / 2 - 1);
  localparam logic [BW-1:0] REG_LAST = BW'(REG_BYTES - 1);
  localparam logic [BW-1:0] DAT_LAST = BW'(DATA_BYTES - 1);
  localparam logic [3:0]    ACK_BIT  = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ID, S_REG, S_WDATA, S_RSTART, S_RDATA, S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           ph_q, ph_d;
  logic                    hi_q, hi_d;
  logic [3:0]              bit_q, bit_d;
  logic [BW-1:0]           byte_q, byte_d;
  logic                    rd_id_q, rd_id_d;
  logic                    rw_q, rw_d;
  logic [8*REG_BYTES-1:0]  reg_addr_q, reg_addr_d;
  logic [8*DATA_BYTES-1:0] wdata_q, wdata_d;
  logic [8*DATA_BYTES-1:0] rx_q, rx_d;
  logic [8*DATA_BYTES-1:0] rdata_q, rdata_d;
  logic                    sda_oe_q, sda_oe_d;
  logic                    scl_q, scl_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    nack_q, nack_d;

  logic [7:0] reg_byte, wd_byte, cur_byte;
  logic       tx_bit;
  logic       drive_pt, hi_pre, sample_pt, cell_end;

  // Timing points inside a bit cell: SDA drive point in the low phase,
  // the matching point in the high phase, iSDA sample point, cell end.
  assign drive_pt  = !hi_q && (ph_q == PH_PRE);
  assign hi_pre    = hi_q && (ph_q == PH_PRE);
  assign sample_pt = hi_q && (ph_q == PH_MID);
  assign cell_end  = hi_q && (ph_q == PH_LAST);

  // Select the byte currently being shifted out and its active bit.
  always_comb begin
    reg_byte = 8'h00;
    for (int i = 0; i < REG_BYTES; i++)
      if (byte_q == BW'(i)) reg_byte = reg_addr_q[8*(REG_BYTES-1-i) +: 8];
    wd_byte = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++)
      if (byte_q == BW'(i)) wd_byte = wdata_q[8*(DATA_BYTES-1-i) +: 8];
    case (state_q)
      S_ID:    cur_byte = {SLAVE_ID, rd_id_q};
      S_REG:   cur_byte = reg_byte;
      S_WDATA: cur_byte = wd_byte;
      default: cur_byte = 8'h00;
    endcase
  end

  assign tx_bit = cur_byte[3'd7 - bit_q[2:0]];

  // Next-state logic for the sequencer, counters and registered outputs.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    hi_d       = hi_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    rd_id_d    = rd_id_q;
    rw_d       = rw_q;
    reg_addr_d = reg_addr_q;
    wdata_d    = wdata_q;
    rx_d       = rx_q;
    rdata_d    = rdata_q;
    sda_oe_d   = sda_oe_q;
    scl_d      = scl_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    nack_d     = nack_q;

    // START is treated as a high half, so SCL falls when it completes.
    if (state_q != S_IDLE) begin
      if (ph_q == PH_LAST) begin
        ph_d  = '0;
        hi_d  = !hi_q;
        scl_d = !hi_q;
      end else begin
        ph_d = ph_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_START;
          busy_d     = 1'b1;
          scl_d      = 1'b1;
          sda_oe_d   = 1'b1;
          ph_d       = '0;
          hi_d       = 1'b1;
          bit_d      = '0;
          byte_d     = '0;
          rd_id_d    = 1'b0;
          nack_d     = 1'b0;
          rw_d       = rw;
          reg_addr_d = reg_addr;
          wdata_d    = wdata;
        end
      end
      S_START: begin
        if (ph_q == PH_LAST) begin
          state_d = S_ID;
          bit_d   = '0;
        end
      end
      S_ID, S_REG, S_WDATA: begin
        if (drive_pt) sda_oe_d = (bit_q == ACK_BIT) ? 1'b0 : !tx_bit;
        if (sample_pt && (bit_q == ACK_BIT) && iSDA) nack_d = 1'b1;
        if (cell_end) begin
          if (bit_q != ACK_BIT) begin
            bit_d = bit_q + 1'b1;
          end else begin
            bit_d = '0;
            if (nack_q) begin
              state_d = S_STOP;
            end else if (state_q == S_ID) begin
              byte_d  = '0;
              state_d = rd_id_q ? S_RDATA : S_REG;
            end else if (state_q == S_REG) begin
              if (byte_q == REG_LAST) begin
                byte_d  = '0;
                state_d = rw_q ? S_RSTART : S_WDATA;
              end else begin
                byte_d = byte_q + 1'b1;
              end
            end else begin
              if (byte_q == DAT_LAST) state_d = S_STOP;
              else byte_d = byte_q + 1'b1;
            end
          end
        end
      end
      S_RSTART: begin
        if (drive_pt) sda_oe_d = 1'b0;
        if (hi_pre) sda_oe_d = 1'b1;
        if (cell_end) begin
          state_d = S_ID;
          rd_id_d = 1'b1;
          bit_d   = '0;
        end
      end
      S_RDATA: begin
        // Master ACKs every read byte except the last one.
        if (drive_pt) sda_oe_d = (bit_q == ACK_BIT) && (byte_q != DAT_LAST);
        if (sample_pt && (bit_q != ACK_BIT)) rx_d = {rx_q[8*DATA_BYTES-2:0], iSDA};
        if (cell_end) begin
          if (bit_q != ACK_BIT) begin
            bit_d = bit_q + 1'b1;
          end else begin
            bit_d = '0;
            if (byte_q == DAT_LAST) state_d = S_STOP;
            else byte_d = byte_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (drive_pt) sda_oe_d = 1'b1;
        if (hi_pre) sda_oe_d = 1'b0;
        if (cell_end) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          scl_d   = 1'b1;
          if (rw_q) rdata_d = rx_q;
        end
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      hi_q       <= 1'b1;
      bit_q      <= '0;
      byte_q     <= '0;
      rd_id_q    <= 1'b0;
      rw_q       <= 1'b0;
      reg_addr_q <= '0;
      wdata_q    <= '0;
      rx_q       <= '0;
      rdata_q    <= '0;
      sda_oe_q   <= 1'b0;
      scl_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      hi_q       <= hi_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      rd_id_q    <= rd_id_d;
      rw_q       <= rw_d;
      reg_addr_q <= reg_addr_d;
      wdata_q    <= wdata_d;
      rx_q       <= rx_d;
      rdata_q    <= rdata_d;
      sda_oe_q   <= sda_oe_d;
      scl_q      <= scl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
    end
  end

  assign sda_oe = sda_oe_q;
  assign SCL    = scl_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign nack   = nack_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_i2c_master_txgen.sv
// Directed bench for i2c_master_txgen: a default-parameter instance (a) and a
// HALF=4 / REG_BYTES=1 / DATA_BYTES=4 instance (b) share one slave model
// through a bus select.
module tb_i2c_master_txgen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic sel;

  logic        start_a, rw_a, oe_a, scl_a, busy_a, done_a, nack_a;
  logic [15:0] reg_addr_a, wdata_a, rdata_a;

  logic        start_b, rw_b, oe_b, scl_b, busy_b, done_b, nack_b;
  logic [7:0]  reg_addr_b;
  logic [31:0] wdata_b, rdata_b;

  logic pull = 1'b0;
  logic scl_bus, oe_bus, sda_bus;
  assign scl_bus = sel ? scl_b : scl_a;
  assign oe_bus  = sel ? oe_b : oe_a;
  assign sda_bus = !(oe_bus || pull);

  i2c_master_txgen #(.HALF(125), .SLAVE_ID(7'h7F), .REG_BYTES(2), .DATA_BYTES(2)) dut_a (
    .CLK(clk), .Reset(rst_n), .start(start_a), .rw(rw_a), .reg_addr(reg_addr_a),
    .wdata(wdata_a), .iSDA(sda_bus), .sda_oe(oe_a), .SCL(scl_a), .busy(busy_a),
    .done(done_a), .nack(nack_a), .rdata(rdata_a));

  i2c_master_txgen #(.HALF(4), .SLAVE_ID(7'h7F), .REG_BYTES(1), .DATA_BYTES(4)) dut_b (
    .CLK(clk), .Reset(rst_n), .start(start_b), .rw(rw_b), .reg_addr(reg_addr_b),
    .wdata(wdata_b), .iSDA(sda_bus), .sda_oe(oe_b), .SCL(scl_b), .busy(busy_b),
    .done(done_b), .nack(nack_b), .rdata(rdata_b));

  // Slave model: decodes START/STOP and bytes, ACKs writes, serves read data.
  bit         scl_p = 1'b1, sda_p = 1'b1;
  int         cnt = 0, rd_idx = 0;
  bit         rd_mode = 1'b0, pend_rd = 1'b0, first = 1'b0;
  logic [7:0] sh = 8'h00;
  logic [7:0] blog[$];
  bit         mack_log[$];
  int         start_cnt = 0, stop_cnt = 0;
  bit         nack_id;
  logic [7:0] rd_bytes [2];

  always @(negedge clk) begin : slave
    bit scl_n, sda_n;
    scl_n = scl_bus;
    sda_n = !(oe_bus || pull);
    if (scl_p && scl_n && sda_p && !sda_n) begin
      cnt = 0; rd_mode = 1'b0; pend_rd = 1'b0; first = 1'b1; start_cnt++;
    end else if (scl_p && scl_n && !sda_p && sda_n) begin
      cnt = 0; rd_mode = 1'b0; stop_cnt++;
    end else if (!scl_p && scl_n) begin
      if (cnt < 8) begin
        sh = {sh[6:0], sda_n};
        cnt++;
      end else begin
        if (rd_mode) begin mack_log.push_back(sda_n); rd_idx++; end
        cnt = 0;
      end
    end else if (scl_p && !scl_n) begin
      if (cnt == 8 && !rd_mode) begin
        blog.push_back(sh);
        pull = !(first && nack_id);
        if (sh == 8'hFF) pend_rd = 1'b1;
        first = 1'b0;
      end else if (cnt == 8) begin
        pull = 1'b0;
      end else if (cnt == 0) begin
        pull = 1'b0;
        if (pend_rd) begin rd_mode = 1'b1; rd_idx = 0; pend_rd = 1'b0; end
        if (rd_mode && rd_idx < 2 && (rd_idx == 0 || mack_log[$] == 1'b0))
          pull = !rd_bytes[rd_idx][7];
      end else if (rd_mode && rd_idx < 2) begin
        pull = !rd_bytes[rd_idx][7-cnt];
      end
    end
    scl_p = scl_n;
    sda_p = !(oe_bus || pull);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bytes(input string tag, input int base, input int nb, input logic [63:0] exp);
    check($sformatf("%s_nbytes", tag), blog.size() - base, nb);
    for (int i = 0; i < nb; i++)
      check($sformatf("%s_byte%0d", tag, i), blog[base+i], {24'h0, exp[8*(nb-1-i) +: 8]});
  endtask

  task automatic wait_end(input bit s, output int n);
    n = 0;
    while ((s ? busy_b : busy_a) === 1'b1 && n < 20000) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, base, s0, p0, m0;
    bit saw_done;
    rst_n = 1'b0; sel = 1'b0; nack_id = 1'b0;
    rd_bytes[0] = 8'hA5; rd_bytes[1] = 8'h3C;
    start_a = 1'b0; rw_a = 1'b0; reg_addr_a = '0; wdata_a = '0;
    start_b = 1'b0; rw_b = 1'b0; reg_addr_b = '0; wdata_b = '0;
    repeat (3) @(negedge clk);

    check("rst_sda_oe", oe_a, 0);
    check("rst_scl", scl_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_nack", nack_a, 0);
    check("rst_rdata", rdata_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Default write
    base = blog.size(); s0 = start_cnt; p0 = stop_cnt;
    rw_a = 1'b0; reg_addr_a = 16'h0050; wdata_a = 16'h0001;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    check("wr_busy_rise", busy_a, 1);
    wait_end(1'b0, n);
    check("wr_busy_len", n, 11625);
    check("wr_done", done_a, 1);
    check("wr_nack", nack_a, 0);
    check("wr_scl_idle", scl_a, 1);
    check_bytes("wr", base, 5, 64'hFE_00_50_00_01);
    check("wr_starts", start_cnt - s0, 1);
    check("wr_stops", stop_cnt - p0, 1);
    @(negedge clk);
    check("wr_done_pulse", done_a, 0);

    // Default read
    base = blog.size(); s0 = start_cnt; p0 = stop_cnt; m0 = mack_log.size();
    rw_a = 1'b1; reg_addr_a = 16'h0050; wdata_a = 16'hFFFF;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    wait_end(1'b0, n);
    check("rd_busy_len", n, 14125);
    check("rd_done", done_a, 1);
    check("rd_rdata", rdata_a, 16'hA53C);
    check("rd_nack", nack_a, 0);
    check_bytes("rd", base, 4, 64'hFE_00_50_FF);
    check("rd_starts", start_cnt - s0, 2);
    check("rd_stops", stop_cnt - p0, 1);
    check("rd_mack_n", mack_log.size() - m0, 2);
    check("rd_mack0", mack_log[m0], 0);
    check("rd_mack1", mack_log[m0+1], 1);
    @(negedge clk);

    // Address NACK
    base = blog.size(); p0 = stop_cnt;
    nack_id = 1'b1; rw_a = 1'b0;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    wait_end(1'b0, n);
    check("nk_busy_len", n, 2625);
    check("nk_done", done_a, 1);
    check("nk_nack", nack_a, 1);
    check_bytes("nk", base, 1, 64'hFE);
    check("nk_stops", stop_cnt - p0, 1);
    @(negedge clk);
    check("nk_sticky", nack_a, 1);

    // Next start clears nack; then reset during REG byte bit 3
    nack_id = 1'b0; rw_a = 1'b0; reg_addr_a = 16'h0050; wdata_a = 16'h1234;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    check("nk_clear", nack_a, 0);
    repeat (3200) @(negedge clk);
    check("mid_busy", busy_a, 1);
    check("mid_scl", scl_a, 0);
    check("mid_sda_oe", oe_a, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_sda_oe", oe_a, 0);
    check("abort_scl", scl_a, 1);
    check("abort_busy", busy_a, 0);
    check("abort_done", done_a, 0);
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_a === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);

    // Parameter sweep on instance b
    sel = 1'b1;
    @(negedge clk);
    base = blog.size();
    rw_b = 1'b0; reg_addr_b = 8'h3A; wdata_b = 32'hDEADBEEF;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    wait_end(1'b1, n);
    check("sw_busy_len", n, 444);
    check("sw_done", done_b, 1);
    check("sw_nack", nack_b, 0);
    check("sw_rdata", rdata_b, 0);
    check_bytes("sw", base, 6, 64'hFE_3A_DE_AD_BE_EF);
    @(negedge clk);

    // Start while busy is ignored; start in the done cycle launches next
    base = blog.size(); s0 = start_cnt;
    rw_b = 1'b0; reg_addr_b = 8'h11; wdata_b = 32'h12345678;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    repeat (200) @(negedge clk);
    rw_b = 1'b1; reg_addr_b = 8'h99; wdata_b = 32'h0;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    wait_end(1'b1, n);
    check("sb_busy_rest", n, 243);
    check("sb_done", done_b, 1);
    check_bytes("sb", base, 6, 64'hFE_11_12_34_56_78);
    check("sb_starts", start_cnt - s0, 1);
    base = blog.size();
    rw_b = 1'b0; reg_addr_b = 8'h22; wdata_b = 32'hCAFEF00D;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    check("b2b_busy", busy_b, 1);
    check("b2b_done_low", done_b, 0);
    wait_end(1'b1, n);
    check("b2b_busy_len", n, 444);
    check("b2b_done", done_b, 1);
    check_bytes("b2b", base, 6, 64'hFE_22_CA_FE_F0_0D);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
